// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory port, decode handshake, redirect and status
interface fetch_unit_if;
  logic [31:0] inst_add;
  logic [31:0] inst_code;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_done;
  logic        misalign_err;

  modport master (
    output inst_add, id_valid, id_inst, id_pc, id_pc_plus4, fetch_done, misalign_err,
    input  inst_code, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  inst_add, id_valid, id_inst, id_pc, id_pc_plus4, fetch_done, misalign_err,
    output inst_code, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and 2-entry fetch buffer feeding decode, with redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] LAST_ADDR = 32'd40,
  parameter int          DEPTH     = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic        r_misalign_err;
  logic [31:0] r_buf_inst [0:1];
  logic [31:0] r_buf_pc   [0:1];

  logic w_pop;
  logic w_push;
  logic w_fetch_done;
  logic w_redirect;

  assign w_fetch_done = r_pc > LAST_ADDR;
  assign w_pop        = (r_count != 2'd0) && bus.id_ready;
  // Once misaligned, the unit is frozen: redirects no longer flush or steer.
  assign w_redirect   = bus.redirect_valid && !r_misalign_err;
  assign w_push       = !w_redirect && !w_fetch_done && !r_misalign_err &&
                        ((int'(r_count) < DEPTH) || w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc           <= RESET_PC;
      r_count        <= 2'd0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_misalign_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_inst[i] <= 32'd0;
        r_buf_pc[i]   <= 32'd0;
      end
    end else if (w_redirect) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      if (bus.redirect_target[1:0] == 2'b00) begin
        r_pc <= bus.redirect_target;
      end else begin
        r_misalign_err <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_buf_inst[r_wr_ptr] <= bus.inst_code;
        r_buf_pc[r_wr_ptr]   <= r_pc;
        r_wr_ptr             <= ~r_wr_ptr;
        r_pc                 <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.inst_add     = r_pc;
  assign bus.id_valid     = r_count != 2'd0;
  assign bus.id_inst      = r_buf_inst[r_rd_ptr];
  assign bus.id_pc        = r_buf_pc[r_rd_ptr];
  assign bus.id_pc_plus4  = r_buf_pc[r_rd_ptr] + 32'd4;
  assign bus.fetch_done   = w_fetch_done;
  assign bus.misalign_err = r_misalign_err;
endmodule
